// File: rtl/jtkunio_pkg.sv
// rtl/jtkunio_pkg.sv - shared types and helpers for the Kunio ADPCM playback sequencer
package jtkunio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PLAY  = 2'd2
    } state_t;

    // control register layout: {oki_s, bank_ce[2:0], msb[1:0]}
    localparam int CTRL_OKI  = 5;
    localparam int CTRL_BANK = 2;
    localparam int CTRL_MSB  = 0;

    // one-hot bank enable to bank number; malformed patterns fall back to bank 0
    function automatic logic [1:0] bank_decode(input logic [2:0] ce);
        case (ce)
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/jtkunio_pcm_fetch.sv
// rtl/jtkunio_pcm_fetch.sv - two-byte PCM ROM prefetch buffer with stale-ok guard
module jtkunio_pcm_fetch #(
    parameter int CNTW = 14,
    parameter int AW   = 17
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear,
    input  logic              abort,
    input  logic              enable,
    input  logic              consume,
    input  logic [AW-CNTW:0]  base,
    input  logic [7:0]        pcm_data,
    input  logic              pcm_ok,
    output logic [AW-1:0]     pcm_addr,
    output logic              pcm_cs,
    output logic [7:0]        cur,
    output logic              cur_valid
);
    localparam int FW = CNTW - 1;

    logic [FW-1:0] fcnt;
    logic [7:0]    nxt;
    logic          nxt_valid;
    logic          fresh;       // first cycle on a new address: ok may belong to the old one
    logic          last_done;   // the final byte of the sample has been loaded

    logic          load;
    logic [7:0]    cur_n;
    logic [7:0]    nxt_n;
    logic          cur_v_n;
    logic          nxt_v_n;
    logic          done_n;
    logic [FW-1:0] fcnt_n;
    logic          need;

    assign load = pcm_cs && pcm_ok && !fresh;

    // buffer update: shift on consume, then drop a loaded byte into the first empty slot
    always_comb begin
        cur_n   = cur;
        cur_v_n = cur_valid;
        nxt_n   = nxt;
        nxt_v_n = nxt_valid;
        fcnt_n  = fcnt;
        done_n  = last_done;
        need    = 1'b0;
        if (consume) begin
            cur_n   = nxt;
            cur_v_n = nxt_valid;
            nxt_v_n = 1'b0;
        end
        if (load) begin
            if (!cur_v_n) begin
                cur_n   = pcm_data;
                cur_v_n = 1'b1;
            end else begin
                nxt_n   = pcm_data;
                nxt_v_n = 1'b1;
            end
            if (fcnt == '1) done_n = 1'b1;
            else            fcnt_n = fcnt + 1'b1;
        end
        need = !done_n && !nxt_v_n;
    end

    // request sequencing: hold pcm_cs until accepted, reissue only while a slot is free
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fcnt      <= '0;
            cur       <= '0;
            nxt       <= '0;
            cur_valid <= 1'b0;
            nxt_valid <= 1'b0;
            last_done <= 1'b0;
            fresh     <= 1'b0;
            pcm_cs    <= 1'b0;
            pcm_addr  <= '0;
        end else if (clear) begin
            fcnt      <= '0;
            cur       <= '0;
            nxt       <= '0;
            cur_valid <= 1'b0;
            nxt_valid <= 1'b0;
            last_done <= 1'b0;
            fresh     <= 1'b1;
            pcm_cs    <= 1'b1;
            pcm_addr  <= {base, {FW{1'b0}}};
        end else if (abort || !enable) begin
            pcm_cs    <= 1'b0;
            fresh     <= 1'b0;
        end else begin
            cur       <= cur_n;
            cur_valid <= cur_v_n;
            nxt       <= nxt_n;
            nxt_valid <= nxt_v_n;
            fcnt      <= fcnt_n;
            last_done <= done_n;
            fresh     <= 1'b0;
            if (!pcm_cs || load) begin
                pcm_cs <= need;
                if (need) begin
                    pcm_addr <= {base, fcnt_n};
                    fresh    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/jtkunio_pcm_ctrl.sv
// rtl/jtkunio_pcm_ctrl.sv - ADPCM playback sequencer: control register, nibble counter, NMI
module jtkunio_pcm_ctrl
    import jtkunio_pkg::*;
#(
    parameter int CNTW = 14,
    parameter int AW   = 17
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          stop,
    input  logic          ctrl_we,
    input  logic [5:0]    ctrl_din,
    input  logic          vclk,
    output logic [AW-1:0] pcm_addr,
    output logic          pcm_cs,
    input  logic [7:0]    pcm_data,
    input  logic          pcm_ok,
    output logic [3:0]    pcm_din,
    output logic          dec_rst,
    output logic [1:0]    dec_sel,
    output logic          nmi_n,
    output logic          underrun
);
    state_t            state;
    logic [5:0]        ctrl;
    logic [CNTW-1:0]   cnt;
    logic [7:0]        cur;
    logic              cur_valid;
    logic [AW-CNTW:0]  base;
    logic              play_vclk;
    logic              consume;
    logic              terminal;

    assign base      = {bank_decode(ctrl[CTRL_BANK+:3]), ctrl[CTRL_MSB+:2]};
    assign dec_sel   = {ctrl[CTRL_OKI], 1'b0};
    assign play_vclk = (state == ST_PLAY) && vclk && cur_valid && !start && !stop;
    assign consume   = play_vclk && cnt[0];
    assign terminal  = play_vclk && (cnt == '1);

    // CPU-visible control register, writable in any state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        ctrl <= '0;
        else if (ctrl_we) ctrl <= ctrl_din;
    end

    jtkunio_pcm_fetch #(
        .CNTW (CNTW),
        .AW   (AW)
    ) u_fetch (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (start),
        .abort     (stop || terminal),
        .enable    (state != ST_IDLE),
        .consume   (consume),
        .base      (base),
        .pcm_data  (pcm_data),
        .pcm_ok    (pcm_ok),
        .pcm_addr  (pcm_addr),
        .pcm_cs    (pcm_cs),
        .cur       (cur),
        .cur_valid (cur_valid)
    );

    // playback FSM: start beats stop, nibbles go out on vclk, last nibble raises the NMI
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            pcm_din  <= '0;
            dec_rst  <= 1'b1;
            nmi_n    <= 1'b1;
            underrun <= 1'b0;
        end else if (start) begin
            state    <= ST_FETCH;
            cnt      <= '0;
            underrun <= 1'b0;
            nmi_n    <= 1'b1;
            dec_rst  <= 1'b0;
        end else if (stop) begin
            state    <= ST_IDLE;
            nmi_n    <= 1'b1;
            dec_rst  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    dec_rst <= 1'b1;
                end
                ST_FETCH: begin
                    if (cur_valid) state <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (vclk) begin
                        if (cur_valid) begin
                            pcm_din <= cnt[0] ? cur[7:4] : cur[3:0];
                            cnt     <= cnt + 1'b1;
                            if (cnt == '1) begin
                                nmi_n   <= 1'b0;
                                dec_rst <= 1'b1;
                                state   <= ST_IDLE;
                            end
                        end else begin
                            underrun <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtkunio_pcm_ctrl.sv
// tb/tb_jtkunio_pcm_ctrl.sv - self-checking bench for the ADPCM playback sequencer
module tb_jtkunio_pcm_ctrl;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        ctrl_we = 1'b0;
    logic [5:0]  ctrl_din = '0;
    logic        vclk = 1'b0;
    logic [16:0] pcm_addr;
    logic        pcm_cs;
    logic [7:0]  pcm_data;
    logic        pcm_ok;
    logic [3:0]  pcm_din;
    logic        dec_rst;
    logic [1:0]  dec_sel;
    logic        nmi_n;
    logic        underrun;

    jtkunio_pcm_ctrl dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .stop     (stop),
        .ctrl_we  (ctrl_we),
        .ctrl_din (ctrl_din),
        .vclk     (vclk),
        .pcm_addr (pcm_addr),
        .pcm_cs   (pcm_cs),
        .pcm_data (pcm_data),
        .pcm_ok   (pcm_ok),
        .pcm_din  (pcm_din),
        .dec_rst  (dec_rst),
        .dec_sel  (dec_sel),
        .nmi_n    (nmi_n),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ROM model: either a latency counter per address, or ok stuck high with one-cycle-late data
    logic [7:0]  rom [0:131071];
    logic        stuck = 1'b0;
    int          lat = 3;
    logic [17:0] last_key = '0;
    int          held = 0;
    logic [7:0]  data_q = '0;
    int          age;

    assign age      = ({pcm_cs, pcm_addr} != last_key) ? 0 : held;
    assign pcm_ok   = stuck ? 1'b1 : (pcm_cs && age >= lat);
    assign pcm_data = stuck ? data_q : rom[pcm_addr];

    always @(posedge clk) begin
        data_q   <= rom[pcm_addr];
        last_key <= {pcm_cs, pcm_addr};
        held     <= ({pcm_cs, pcm_addr} != last_key) ? 1 : ((held < 100000) ? held + 1 : held);
    end

    // vclk strobe generator
    int   vper = 4;
    int   vcnt = 0;
    logic vclk_en = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        vclk = vclk_en && (vcnt == 0);
        vcnt = (vcnt + 1 >= vper) ? 0 : vcnt + 1;
    end

    // reference model: bytes delivered in order, nibble k needs byte k/2, low nibble first
    logic [5:0] ctrl_sh = '0;
    logic       run = 1'b0;
    logic       playing = 1'b0;
    logic       run_done = 1'b0;
    int         k = 0;
    int         delivered = 0;
    logic [3:0] base = '0;
    logic [3:0] exp_din = '0;
    logic       pend_din = 1'b0;
    logic       pend_hold = 1'b0;
    logic       pend_term = 1'b0;

    function automatic logic [1:0] bank_of(input logic [2:0] ce);
        if (ce == 3'b010) return 2'd1;
        if (ce == 3'b100) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [3:0] nib(input logic [3:0] b, input int n);
        logic [16:0] a;
        logic [7:0]  d;
        a = {b, 13'(n >> 1)};
        d = rom[a];
        return n[0] ? d[7:4] : d[3:0];
    endfunction

    always @(negedge clk) begin
        if (rstn) begin
            if (pend_din) check("nibble", 32'(pcm_din), 32'(exp_din));
            if (pend_hold) begin
                check("din_hold", 32'(pcm_din), 32'(exp_din));
                check("underrun_set", 32'(underrun), 32'd1);
            end
            if (pend_term) begin
                check("term_nmi", 32'(nmi_n), 32'd0);
                check("term_dec_rst", 32'(dec_rst), 32'd1);
                run_done = 1'b1;
            end
        end
        pend_din  = 1'b0;
        pend_hold = 1'b0;
        pend_term = 1'b0;
        if (!rstn) begin
            run     = 1'b0;
            playing = 1'b0;
        end else if (start) begin
            run       = 1'b1;
            run_done  = 1'b0;
            playing   = 1'b0;
            k         = 0;
            delivered = 0;
            base      = {bank_of(ctrl_sh[4:2]), ctrl_sh[1:0]};
        end else if (stop) begin
            run = 1'b0;
        end else if (run) begin
            if (playing && vclk) begin
                if ((k >> 1) < delivered) begin
                    exp_din  = nib(base, k);
                    pend_din = 1'b1;
                    if (k == 16383) begin
                        pend_term = 1'b1;
                        run       = 1'b0;
                    end
                    k++;
                end else begin
                    pend_hold = 1'b1;
                end
            end
            playing = (delivered >= 1);
            if (pcm_cs && pcm_ok && age >= 1) begin
                check("fetch_addr", 32'(pcm_addr), 32'({base, 13'(delivered)}));
                delivered++;
            end
        end
    end

    task automatic write_ctrl(input logic [5:0] v);
        @(posedge clk);
        #1 ctrl_we = 1'b1; ctrl_din = v; ctrl_sh = v;
        @(posedge clk);
        #1 ctrl_we = 1'b0;
    endtask

    task automatic pulse(input logic s, input logic p);
        @(posedge clk);
        #1 start = s; stop = p;
        @(posedge clk);
        #1 start = 1'b0; stop = 1'b0;
    endtask

    task automatic wait_k(input int target, input int lim);
        int n;
        n = 0;
        while (k < target && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("wait_k_in_time", 32'(k >= target), 32'd1);
    endtask

    initial begin
        int n;
        logic [2:0] ce;
        for (int i = 0; i < 131072; i++) rom[i] = 8'($urandom);

        // reset values
        repeat (3) @(negedge clk);
        check("rst_cs", 32'(pcm_cs), 32'd0);
        check("rst_addr", 32'(pcm_addr), 32'd0);
        check("rst_din", 32'(pcm_din), 32'd0);
        check("rst_dec_rst", 32'(dec_rst), 32'd1);
        check("rst_dec_sel", 32'(dec_sel), 32'd0);
        check("rst_nmi", 32'(nmi_n), 32'd1);
        check("rst_underrun", 32'(underrun), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // full-length run, bank 1 msb 3, 3-cycle ROM
        write_ctrl(6'b0_010_11);
        vclk_en = 1'b1;
        pulse(1'b1, 1'b0);
        @(negedge clk);
        check("first_cs", 32'(pcm_cs), 32'd1);
        check("first_addr", 32'(pcm_addr), 32'h0E000);
        check("start_dec_rst", 32'(dec_rst), 32'd0);
        check("dec_sel_oki0", 32'(dec_sel), 32'd0);
        n = 0;
        while (!run_done && n < 70000) begin
            @(negedge clk);
            n++;
        end
        check("run_done_in_time", 32'(run_done), 32'd1);
        @(negedge clk);
        check("end_nibbles", 32'(k), 32'd16384);
        check("end_dec_rst", 32'(dec_rst), 32'd1);
        check("end_cs", 32'(pcm_cs), 32'd0);
        check("end_underrun", 32'(underrun), 32'd0);
        repeat (20) @(negedge clk);
        check("nmi_held", 32'(nmi_n), 32'd0);

        // restart raises nmi_n; then stop mid-sample
        write_ctrl(6'b1_100_01);
        pulse(1'b1, 1'b0);
        @(negedge clk);
        check("restart_nmi", 32'(nmi_n), 32'd1);
        check("dec_sel_oki1", 32'(dec_sel), 32'd2);
        check("bank2_addr", 32'(pcm_addr), 32'({2'd2, 2'd1, 13'd0}));
        wait_k(100, 2000);
        pulse(1'b0, 1'b1);
        @(negedge clk);
        check("stop_cs", 32'(pcm_cs), 32'd0);
        check("stop_dec_rst", 32'(dec_rst), 32'd1);
        check("stop_nmi", 32'(nmi_n), 32'd1);
        n = 0;
        repeat (50) begin
            @(negedge clk);
            if (pcm_cs) n++;
        end
        check("no_req_after_stop", 32'(n), 32'd0);

        // start and stop together during play: start wins; malformed bank -> 0
        write_ctrl(6'b0_011_10);
        pulse(1'b1, 1'b0);
        wait_k(40, 1000);
        pulse(1'b1, 1'b1);
        @(negedge clk);
        check("both_addr", 32'(pcm_addr), 32'({2'd0, 2'd2, 13'd0}));
        check("both_cs", 32'(pcm_cs), 32'd1);
        check("both_nmi", 32'(nmi_n), 32'd1);
        check("both_dec_rst", 32'(dec_rst), 32'd0);
        wait_k(60, 1000);
        pulse(1'b0, 1'b1);

        // slow ROM: underrun, no skipped nibbles
        lat = 400;
        vper = 100;
        write_ctrl(6'b0_001_01);
        pulse(1'b1, 1'b0);
        wait_k(8, 6000);
        check("slow_underrun", 32'(underrun), 32'd1);
        pulse(1'b0, 1'b1);
        lat = 3;
        vper = 4;

        // ok stuck high with late data: guard must skip the stale cycle
        stuck = 1'b1;
        case ($urandom_range(2))
            0:       ce = 3'b001;
            1:       ce = 3'b010;
            default: ce = 3'b100;
        endcase
        write_ctrl({1'b0, ce, 2'($urandom)});
        pulse(1'b1, 1'b0);
        wait_k(40, 2000);
        check("stuck_underrun", 32'(underrun), 32'd0);
        pulse(1'b0, 1'b1);
        stuck = 1'b0;

        // asynchronous reset mid-run
        write_ctrl(6'b0_100_00);
        pulse(1'b1, 1'b0);
        wait_k(10, 1000);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("async_cs", 32'(pcm_cs), 32'd0);
        check("async_addr", 32'(pcm_addr), 32'd0);
        check("async_dec_rst", 32'(dec_rst), 32'd1);
        check("async_nmi", 32'(nmi_n), 32'd1);
        ctrl_sh = '0;
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
